// File: rtl/wide_cmp_seq.sv
// wide_cmp_seq: sequential magnitude comparator for wide operands.
// Compares captured operands one SLICE-bit slice per cycle, starting at the
// MSB slice, and stops at the first unequal slice. The result is registered
// and held until the next comparison finishes or reset.
//
// Parameters:
//   WIDTH  operand width in bits (integer multiple of SLICE)
//   SLICE  bits compared per cycle; NS = WIDTH/SLICE slices
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  request a comparison; accepted only when busy=0
//   sgn    (only with WIDE_CMP_SEQ_SIGNED_EN) two's-complement compare,
//          sampled with start
//   a, b   operands, sampled on an accepted start
//   busy   comparison in progress
//   done   one-cycle pulse, result valid
//   eq/gt/lt registered one-hot result
//
// Optional feature macro: WIDE_CMP_SEQ_SIGNED_EN (adds the sgn port).
module wide_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef WIDE_CMP_SEQ_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [WIDTH-1:0] flip;
    logic [SLICE-1:0] sa, sb;
    logic             cap;

    // Inverting the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the scan itself stays unsigned.
    always_comb begin
        flip = '0;
`ifdef WIDE_CMP_SEQ_SIGNED_EN
        flip[WIDTH-1] = sgn;
`endif
    end

    assign sa = a_q[int'(idx_q) * SLICE +: SLICE];
    assign sb = b_q[int'(idx_q) * SLICE +: SLICE];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        cap     = 1'b0;

        case (state_q)
            IDLE: begin
                cap = start;
            end
            SCAN: begin
                if (sa != sb) begin
                    // Early exit: lower slices cannot change the outcome.
                    gt_d    = (sa > sb);
                    lt_d    = (sa < sb);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    cap = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared capture path for IDLE and back-to-back start in DONE.
        if (cap) begin
            a_d     = a ^ flip;
            b_d     = b ^ flip;
            idx_d   = IDX_TOP;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule
